paicore_tx_mc: RTL and testbench
================================

// Module: paicore_tx_mc
// PURPOSE
//  Next-gen AXI-Stream -> PAICORE multi-channel sender. Takes DATA_WIDTH beats from DMA and splits each into
//  DATA_WIDTH/PDATA_WIDTH words sent LS-first. Words go out on CHANNELS 4-phase req/ack parallel links.
//  Adds round-robin distribution over a channel mask, a len-0 "unlimited" mode, ack sync and busy/done status.
//  Sits between the DMA MM2S stream and the io_ctrl tristate layer (send direction only).
// PARAMETERS
//  CHANNELS        4     number of req/ack/pdata links
//  DATA_WIDTH      64    AXIS tdata width; integer multiple of PDATA_WIDTH
//  PDATA_WIDTH     32    per-link data width; WORDS = DATA_WIDTH/PDATA_WIDTH
//  SYNC_STAGES     2     acknowledge synchroniser depth (>=2)
//  TIMEOUT_CYCLES  1024  ack watchdog limit (only with PAICORE_TX_ACK_TIMEOUT_EN)
// PORTS
//  s_axis_aclk     in   1                  sole clock
//  s_axis_aresetn  in   1                  async active-low reset
//  en              in   1                  level; 0 = accept no new beats
//  start           in   1                  pulse; clears counters/tx_done, arms run
//  single_channel  in   1                  1 = all beats to sel_ch; 0 = round-robin over chan_mask
//  sel_ch          in   $clog2(CHANNELS)   target link in single mode
//  chan_mask       in   CHANNELS           enabled links in round-robin mode
//  send_len        in   32                 beats per run; 0 = unlimited
//  data_cnt        out  32                 beats accepted this run
//  tlast_cnt       out  32                 tlast beats accepted this run
//  busy            out  1                  any link not IDLE
//  tx_done         out  1                  sticky run-complete
//  err_timeout     out  CHANNELS           sticky per-link ack timeout
//  s_axis_tready   out  1                  AXIS handshake
//  s_axis_tdata    in   DATA_WIDTH         AXIS handshake
//  s_axis_tlast    in   1                  AXIS handshake
//  s_axis_tvalid   in   1                  AXIS handshake
//  request         out  CHANNELS           4-phase req per link
//  pdata           out  CHANNELS*PDATA_WIDTH  link data, ch0 at LSBs
//  acknowledge     in   CHANNELS           async ack per link, synchronised internally
// BEHAVIOUR
//  Reset: all outputs 0; links IDLE; RR pointer 0; run disarmed.
//  Target: single -> sel_ch. RR -> first masked link at/after pointer (wraps). Pointer -> target+1 after each accepted beat.
//  tready = armed & en & ~tx_done & target valid & target IDLE. Mask==0 in RR mode -> tready=0.
//  Beat accepted on tvalid&tready. Beat is latched into the target link and launches its FSM.
//  The next beat may go to another IDLE link in the following cycle.
//  Link FSM: IDLE -> REQ (pdata=word k, request=1) -> ack_s=1 -> REL (request=0) -> ack_s=0 -> k+1 < WORDS ? REQ : IDLE.
//  pdata stable from REQ entry until REL exit; request registered (no glitch). ack latency = SYNC_STAGES cycles.
//  Counters: data_cnt++ on each accepted beat; tlast_cnt++ when tlast is also set; both wrap at 2^32.
//  tx_done: set 1 cycle after data_cnt==send_len (send_len!=0) and all links IDLE. Clears on start.
//  While tx_done=1 or send_len reached: tready=0.
//  start same cycle as a beat: start wins; beat not accepted; counters=0.
//  start while busy: counters clear; in-flight handshakes complete normally.
//  en->0 mid-handshake: in-flight words finish; no new beats.
//  Mask/sel_ch change mid-run: applies at next target selection only.
//  Async reset mid-handshake: request drops immediately; partial beat discarded.
// CONFIGURATION
//  PAICORE_TX_ACK_TIMEOUT_EN defined: per-link counter runs in REQ/REL; clears on each state change.
//   On reaching TIMEOUT_CYCLES: link forced IDLE, request=0, remaining words of the beat dropped,
//   err_timeout[ch] set (sticky until start). data_cnt is not rolled back, so tx_done is still reachable.
//  Undefined: links wait indefinitely; err_timeout tied to 0; port kept.
// STRUCTURE
//  Package paicore_tx_pkg: link state encoding (IDLE/REQ/REL), WORDS, CH_W=$clog2(CHANNELS),
//   and the mask-rotate next-target function.
//  Sub-module paicore_tx_link: one 4-phase link FSM with ack synchroniser, beat register,
//   word index and optional watchdog; instantiated CHANNELS times by generate.
//  Top holds dispatch, RR pointer, counters and done logic.
// TESTING
//  1. Single mode, sel_ch=2, send_len=3, ack echoes req after 3 cycles:
//     6 handshakes on link 2 only, LS word first; data_cnt=3; tx_done=1; tready=0 after.
//  2. RR, mask=4'b1011, 6 beats: link order 0,1,3,0,1,3; link 2 request never toggles.
//  3. send_len=0, 100 beats with 10 tlast: data_cnt=100, tlast_cnt=10, tx_done stays 0.
//  4. Link 1 ack held low for 50 cycles: request[1] stays 1 and pdata stays stable;
//     tready=0 only when RR target is link 1.
//  5. start together with tvalid, then async reset mid-REQ:
//     beat rejected, counters 0; request drops same cycle as reset; all outputs 0.
//  6. With PAICORE_TX_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16, link 0 never acks:
//     err_timeout[0]=1 after 16 cycles; link 0 IDLE; run still reaches tx_done.

Source files
------------

// File: rtl/paicore_tx_pkg.sv
// ============================================================================
// Module      : paicore_tx_pkg
// Description : Shared types and helpers for the PAICORE multi-channel sender.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package paicore_tx_pkg;

    localparam int MAX_CH          = 32;
    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_PDATA_WIDTH = 32;
    localparam int WORDS           = DEF_DATA_WIDTH / DEF_PDATA_WIDTH;
    localparam int CH_W            = $clog2(DEF_CHANNELS);

    typedef enum logic [1:0] {
        LINK_IDLE = 2'd0,
        LINK_REQ  = 2'd1,
        LINK_REL  = 2'd2
    } link_state_e;

    // First set mask bit at or after ptr, wrapping over n links; -1 when mask is empty.
    function automatic int rr_next_target(input logic [MAX_CH-1:0] mask,
                                          input int ptr,
                                          input int n);
        int c;
        rr_next_target = -1;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < n) begin
                c = ptr + i;
                if (c >= n) c = c - n;
                if (mask[c]) rr_next_target = c;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/paicore_tx_link.sv
// ============================================================================
// Module      : paicore_tx_link
// Description : One 4-phase req/ack link: ack synchroniser, beat register,
//               word sequencer; ack watchdog when PAICORE_TX_ACK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module paicore_tx_link
    import paicore_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PDATA_WIDTH    = DEF_PDATA_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic [DATA_WIDTH-1:0]  i_beat,
    input  logic                   i_ack,
    output logic                   o_idle,
    output logic                   o_request,
    output logic [PDATA_WIDTH-1:0] o_pdata,
    output logic                   o_timeout
);

    localparam int N_WORDS = DATA_WIDTH / PDATA_WIDTH;
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    link_state_e            r_state;
    link_state_e            w_next;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [DATA_WIDTH-1:0]  r_beat;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic [PDATA_WIDTH-1:0] r_pdata;
    logic                   r_request;
    logic                   w_ack_s;
    logic                   w_last_word;
    logic                   w_wd_expire;

    assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];
    assign w_last_word = (int'(r_idx) == N_WORDS - 1);

`ifdef PAICORE_TX_ACK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd <= '0;
        end else if (r_state == LINK_IDLE || w_next != r_state) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign w_wd_expire = (r_state != LINK_IDLE) && (int'(r_wd) == TIMEOUT_CYCLES - 1);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_wd_expire      = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        case (r_state)
            LINK_IDLE: begin
                if (i_load) begin
                    w_next     = LINK_REQ;
                    w_idx_next = '0;
                end
            end
            LINK_REQ: begin
                if (w_ack_s) w_next = LINK_REL;
            end
            LINK_REL: begin
                if (!w_ack_s) begin
                    if (w_last_word) begin
                        w_next = LINK_IDLE;
                    end else begin
                        w_next     = LINK_REQ;
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            default: w_next = LINK_IDLE;
        endcase
        // A stalled far end abandons the rest of the beat.
        if (w_wd_expire) w_next = LINK_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= LINK_IDLE;
            r_ack_sync <= '0;
            r_beat     <= '0;
            r_idx      <= '0;
            r_pdata    <= '0;
            r_request  <= 1'b0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack};
            r_state    <= w_next;
            r_idx      <= w_idx_next;
            r_request  <= (w_next == LINK_REQ);
            if (r_state == LINK_IDLE && i_load) begin
                r_beat  <= i_beat;
                r_pdata <= i_beat[PDATA_WIDTH-1:0];
            end else if (r_state == LINK_REL && w_next == LINK_REQ) begin
                r_pdata <= r_beat[int'(w_idx_next)*PDATA_WIDTH +: PDATA_WIDTH];
            end
        end
    end

    assign o_idle    = (r_state == LINK_IDLE);
    assign o_request = r_request;
    assign o_pdata   = r_pdata;
    assign o_timeout = w_wd_expire;

endmodule

`default_nettype wire

// File: rtl/paicore_tx_mc.sv
// ============================================================================
// Module      : paicore_tx_mc
// Description : AXI-Stream to PAICORE multi-channel sender: dispatch, RR
//               pointer, counters, done. Option: PAICORE_TX_ACK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module paicore_tx_mc
    import paicore_tx_pkg::*;
#(
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PDATA_WIDTH    = DEF_PDATA_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                         s_axis_aclk,
    input  logic                                         s_axis_aresetn,
    input  logic                                         en,
    input  logic                                         start,
    input  logic                                         single_channel,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel_ch,
    input  logic [CHANNELS-1:0]                          chan_mask,
    input  logic [31:0]                                  send_len,
    output logic [31:0]                                  data_cnt,
    output logic [31:0]                                  tlast_cnt,
    output logic                                         busy,
    output logic                                         tx_done,
    output logic [CHANNELS-1:0]                          err_timeout,
    output logic                                         s_axis_tready,
    input  logic [DATA_WIDTH-1:0]                        s_axis_tdata,
    input  logic                                         s_axis_tlast,
    input  logic                                         s_axis_tvalid,
    output logic [CHANNELS-1:0]                          request,
    output logic [CHANNELS*PDATA_WIDTH-1:0]              pdata,
    input  logic [CHANNELS-1:0]                          acknowledge
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] w_idle;
    logic [CHANNELS-1:0] w_load;
    logic [CHANNELS-1:0] w_timeout;
    logic [MAX_CH-1:0]   w_mask_ext;
    logic [SEL_W-1:0]    w_target;
    logic                w_target_ok;
    logic                w_len_hit;
    logic                w_ready;
    logic                w_accept;
    int                  w_rr;

    logic [SEL_W-1:0]    r_ptr;
    logic                r_armed;
    logic [31:0]         r_data_cnt;
    logic [31:0]         r_tlast_cnt;
    logic                r_tx_done;
    logic [CHANNELS-1:0] r_err;

    always_comb begin
        w_mask_ext                 = '0;
        w_mask_ext[CHANNELS-1:0]   = chan_mask;
        w_rr                       = rr_next_target(w_mask_ext, int'(r_ptr), CHANNELS);
        if (single_channel) begin
            w_target    = sel_ch;
            w_target_ok = (int'(sel_ch) < CHANNELS);
        end else begin
            w_target    = SEL_W'(w_rr);
            w_target_ok = (w_rr >= 0);
        end
    end

    // >= rather than == so lowering send_len mid-run still closes the run.
    assign w_len_hit = (send_len != 32'd0) && (r_data_cnt >= send_len);
    assign w_ready   = r_armed & en & ~start & ~r_tx_done & ~w_len_hit
                     & w_target_ok & w_idle[w_target];
    assign w_accept  = s_axis_tvalid & w_ready;

    always_comb begin
        w_load           = '0;
        w_load[w_target] = w_accept;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_ptr       <= '0;
            r_armed     <= 1'b0;
            r_data_cnt  <= '0;
            r_tlast_cnt <= '0;
            r_tx_done   <= 1'b0;
            r_err       <= '0;
        end else if (start) begin
            r_ptr       <= '0;
            r_armed     <= 1'b1;
            r_data_cnt  <= '0;
            r_tlast_cnt <= '0;
            r_tx_done   <= 1'b0;
            r_err       <= '0;
        end else begin
            if (w_accept) begin
                r_ptr      <= (int'(w_target) == CHANNELS - 1) ? '0 : w_target + 1'b1;
                r_data_cnt <= r_data_cnt + 32'd1;
                if (s_axis_tlast) r_tlast_cnt <= r_tlast_cnt + 32'd1;
            end
            if (r_armed && w_len_hit && (&w_idle)) r_tx_done <= 1'b1;
            r_err <= r_err | w_timeout;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_link
        paicore_tx_link #(
            .DATA_WIDTH     (DATA_WIDTH),
            .PDATA_WIDTH    (PDATA_WIDTH),
            .SYNC_STAGES    (SYNC_STAGES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_link (
            .i_clk     (s_axis_aclk),
            .i_rst_n   (s_axis_aresetn),
            .i_load    (w_load[g]),
            .i_beat    (s_axis_tdata),
            .i_ack     (acknowledge[g]),
            .o_idle    (w_idle[g]),
            .o_request (request[g]),
            .o_pdata   (pdata[g*PDATA_WIDTH +: PDATA_WIDTH]),
            .o_timeout (w_timeout[g])
        );
    end

    assign data_cnt      = r_data_cnt;
    assign tlast_cnt     = r_tlast_cnt;
    assign busy          = ~(&w_idle);
    assign tx_done       = r_tx_done;
    assign err_timeout   = r_err;
    assign s_axis_tready = w_ready;

endmodule

`default_nettype wire

// File: tb/tb_paicore_tx_mc.sv
// ============================================================================
// Module      : tb_paicore_tx_mc
// Description : Randomised self-checking bench for paicore_tx_mc with a
//               queue-based reference model and far-end ack responders.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_paicore_tx_mc;

    localparam int CH = 4;
    localparam int DW = 64;
    localparam int PW = 32;
    localparam int NW = DW / PW;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          single = 1'b0;
    logic [1:0]    sel_ch = '0;
    logic [CH-1:0] mask = '0;
    logic [31:0]   send_len = '0;
    logic [31:0]   data_cnt;
    logic [31:0]   tlast_cnt;
    logic          busy;
    logic          tx_done;
    logic [CH-1:0] err_to;
    logic          tready;
    logic [DW-1:0] tdata = '0;
    logic          tlast = 1'b0;
    logic          tvalid = 1'b0;
    logic [CH-1:0] request;
    logic [CH*PW-1:0] pdata;
    logic [CH-1:0] ack = '0;

    always #5 clk = ~clk;

    paicore_tx_mc #(
        .CHANNELS       (CH),
        .DATA_WIDTH     (DW),
        .PDATA_WIDTH    (PW),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .en             (en),
        .start          (start),
        .single_channel (single),
        .sel_ch         (sel_ch),
        .chan_mask      (mask),
        .send_len       (send_len),
        .data_cnt       (data_cnt),
        .tlast_cnt      (tlast_cnt),
        .busy           (busy),
        .tx_done        (tx_done),
        .err_timeout    (err_to),
        .s_axis_tready  (tready),
        .s_axis_tdata   (tdata),
        .s_axis_tlast   (tlast),
        .s_axis_tvalid  (tvalid),
        .request        (request),
        .pdata          (pdata),
        .acknowledge    (ack)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [PW-1:0] exp_q [CH][$];
    logic [PW-1:0] exp_cur [CH];
    int            m_ptr = 0;
    logic [31:0]   m_data = '0;
    logic [31:0]   m_tlast = '0;
    int            rises [CH];
    int            ack_dly [CH];
    bit            ack_hold [CH];
    int            ack_cnt [CH];
    logic [CH-1:0] prev_req = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference target choice: sel_ch, or first enabled link scanning from the pointer.
    function automatic int model_target();
        if (single) return int'(sel_ch);
        for (int i = 0; i < CH; i++) begin
            if (mask[(m_ptr + i) % CH]) return (m_ptr + i) % CH;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int c = 0; c < CH; c++) s += exp_q[c].size();
        return s;
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        int t = model_target();
        check_eq("model_target_valid", (t >= 0), 1);
        if (t >= 0) begin
            for (int w = 0; w < NW; w++) exp_q[t].push_back(d[w*PW +: PW]);
            m_ptr = (t + 1) % CH;
        end
        m_data++;
        if (l) m_tlast++;
    endtask

    // Far end: ack follows request after ack_dly cycles unless held.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (!rst_n) begin
                ack[c]     = 1'b0;
                ack_cnt[c] = 0;
            end else if (ack[c] != request[c] && !ack_hold[c]) begin
                ack_cnt[c]++;
                if (ack_cnt[c] >= ack_dly[c]) begin
                    ack[c]     = request[c];
                    ack_cnt[c] = 0;
                end
            end else begin
                ack_cnt[c] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (!rst_n) begin
                prev_req[c] = 1'b0;
            end else begin
                if (request[c] && !prev_req[c]) begin
                    rises[c]++;
                    check_eq($sformatf("word_expected_ch%0d", c), (exp_q[c].size() > 0), 1);
                    if (exp_q[c].size() > 0) begin
                        exp_cur[c] = exp_q[c].pop_front();
                        check_eq($sformatf("word_ch%0d", c), pdata[c*PW +: PW], exp_cur[c]);
                    end
                end
                if (!request[c] && prev_req[c])
                    check_eq($sformatf("pdata_hold_ch%0d", c), pdata[c*PW +: PW], exp_cur[c]);
                prev_req[c] = request[c];
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int n = 0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        #1;
        while (!tready && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("beat_accept_in_time", tready, 1);
        if (tready) model_accept(d, l);
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_ptr   = 0;
        m_data  = '0;
        m_tlast = '0;
        for (int c = 0; c < CH; c++) rises[c] = 0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((busy || pending() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_pending"}, pending(), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!tx_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, tx_done, 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int k;
        logic [DW-1:0] d;
        for (int c = 0; c < CH; c++) begin
            ack_dly[c]  = 3;
            ack_hold[c] = 1'b0;
            rises[c]    = 0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_data_cnt", data_cnt, 0);
        check_eq("rst_tlast_cnt", tlast_cnt, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tx_done", tx_done, 0);
        check_eq("rst_err", err_to, 0);
        check_eq("rst_tready", tready, 0);
        check_eq("rst_request", request, 0);
        check_eq("rst_pdata", |pdata, 0);
        rst_n = 1'b1;

        // single mode, link 2, three beats
        en = 1'b1; single = 1'b1; sel_ch = 2'd2; send_len = 32'd3;
        do_start();
        for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 1'b0);
        wait_done("t1_done");
        check_eq("t1_pending", pending(), 0);
        check_eq("t1_data_cnt", data_cnt, 3);
        check_eq("t1_rises_ch2", rises[2], 3 * NW);
        check_eq("t1_rises_other", rises[0] + rises[1] + rises[3], 0);
        tvalid = 1'b1;
        #1;
        check_eq("t1_tready_after_done", tready, 0);
        tvalid = 1'b0;

        // round robin over 1011
        single = 1'b0; mask = 4'b1011; send_len = 32'd6;
        do_start();
        for (int i = 0; i < 6; i++) send_beat({$urandom, $urandom}, 1'b0);
        wait_done("t2_done");
        check_eq("t2_data_cnt", data_cnt, m_data);
        check_eq("t2_rises_ch0", rises[0], 2 * NW);
        check_eq("t2_rises_ch1", rises[1], 2 * NW);
        check_eq("t2_rises_ch2", rises[2], 0);
        check_eq("t2_rises_ch3", rises[3], 2 * NW);

        // unlimited run, random routing, 10 tlast beats out of 100
        send_len = 32'd0;
        for (int c = 0; c < CH; c++) ack_dly[c] = $urandom_range(1, 6);
        do_start();
        k = $urandom_range(0, 9);
        for (int i = 0; i < 100; i++) begin
            single = ($urandom_range(0, 3) == 0);
            sel_ch = 2'($urandom_range(0, CH - 1));
            mask   = 4'($urandom_range(1, 15));
            send_beat({$urandom, $urandom}, (i % 10) == k);
        end
        wait_drain("t3");
        check_eq("t3_data_cnt", data_cnt, 100);
        check_eq("t3_tlast_cnt", tlast_cnt, 10);
        check_eq("t3_model_cnt", data_cnt, m_data);
        check_eq("t3_tx_done", tx_done, 0);

        // link 1 stalls; RR keeps feeding other links until link 1 is the target
        for (int c = 0; c < CH; c++) ack_dly[c] = 3;
        single = 1'b0; mask = 4'b1111;
        do_start();
        ack_hold[1] = 1'b1;
        for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom}, 1'b0);
        check_eq("t4_model_target", model_target(), 1);
        d      = {$urandom, $urandom};
        tdata  = d;
        tvalid = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        check_eq("t4_tready_stall", tready, 0);
        check_eq("t4_request1_held", request[1], 1);
        check_eq("t4_pdata1_stable", pdata[1*PW +: PW], exp_cur[1]);
        ack_hold[1] = 1'b0;
        send_beat(d, 1'b0);
        wait_drain("t4");
        check_eq("t4_data_cnt", data_cnt, 6);

        // start wins over a simultaneous beat; then async reset mid-REQ
        @(negedge clk);
        tdata  = {$urandom, $urandom};
        tvalid = 1'b1;
        start  = 1'b1;
        #1;
        check_eq("t5_tready_on_start", tready, 0);
        @(negedge clk);
        start = 1'b0; tvalid = 1'b0;
        m_ptr = 0; m_data = '0; m_tlast = '0;
        check_eq("t5_data_cnt_cleared", data_cnt, 0);
        check_eq("t5_tlast_cnt_cleared", tlast_cnt, 0);
        single = 1'b1; sel_ch = 2'd0; ack_hold[0] = 1'b1;
        send_beat({$urandom, $urandom}, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("t5_request0_pre", request[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_request", request, 0);
        check_eq("t5_rst_pdata", |pdata, 0);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_data_cnt", data_cnt, 0);
        check_eq("t5_rst_tlast_cnt", tlast_cnt, 0);
        check_eq("t5_rst_tready", tready, 0);
        check_eq("t5_rst_done_err", {tx_done, err_to}, 0);
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        ack_hold[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef PAICORE_TX_ACK_TIMEOUT_EN
        // link 0 never acknowledges; each beat times out and the run still closes
        single = 1'b1; sel_ch = 2'd0; send_len = 32'd2; ack_hold[0] = 1'b1;
        do_start();
        for (int b = 0; b < 2; b++) begin
            int n = 0;
            send_beat({$urandom, $urandom}, 1'b0);
            while (!err_to[0] && n < 60) begin
                @(negedge clk);
                n++;
            end
            check_eq("t6_err_set", err_to[0], 1);
            if (b == 0) check_eq("t6_not_early", (n >= TO - 3), 1);
            check_eq("t6_request0_low", request[0], 0);
            exp_q[0].delete();
        end
        wait_done("t6_done");
        check_eq("t6_err_sticky", err_to, 4'b0001);
        check_eq("t6_busy", busy, 0);
        ack_hold[0] = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
